// File: rtl/seed_pkg.sv
// Shared sizing constants and FSM state type for the SEED round sequencer.
package seed_pkg;

  localparam int NUM_ROUNDS   = 16;
  localparam int BLOCK_BYTES  = 16;
  localparam int ROUND_CYCLES = 24;

  localparam int MC_W = 5;
  localparam int KR_W = 4;
  localparam int BC_W = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

endpackage

// File: rtl/seed_phase_counter.sv
// Phase-within-round and round-index counter pair for the SEED round sequencer.
// o_last flags the final phase of the final round.
module seed_phase_counter
  import seed_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_en,
  output logic [MC_W-1:0] o_phase,
  output logic [KR_W-1:0] o_round,
  output logic            o_last
);

  localparam logic [MC_W-1:0] LAST_PHASE = MC_W'(ROUND_CYCLES - 1);
  localparam logic [KR_W-1:0] LAST_ROUND = KR_W'(NUM_ROUNDS - 1);

  logic [MC_W-1:0] r_phase;
  logic [KR_W-1:0] r_round;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase <= '0;
      r_round <= '0;
    end else if (i_clear) begin
      r_phase <= '0;
      r_round <= '0;
    end else if (i_en) begin
      if (r_phase == LAST_PHASE) begin
        r_phase <= '0;
        r_round <= r_round + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_round = r_round;
  assign o_last  = (r_phase == LAST_PHASE) && (r_round == LAST_ROUND);

endmodule

// File: rtl/seed_round_sequencer.sv
// Controller for the byte-serial SEED round datapath: load 16 bytes, run the rounds, unload.
// Define SEED_DECRYPT_EN to issue round keys in descending order for decryption.
module seed_round_sequencer
  import seed_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_abort,
  output logic            o_busy,
  input  logic            i_din_valid,
  output logic            o_din_ready,
  output logic            o_lr_sel,
  output logic            o_dp_en,
  output logic [MC_W-1:0] o_main_counter,
  output logic            o_key_req,
  output logic [KR_W-1:0] o_key_round,
  output logic            o_dout_valid,
  output logic            o_done
);

  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BLOCK_BYTES - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [BC_W-1:0] r_byte_cnt;
  logic            r_done;
  logic [KR_W-1:0] r_key_round;
  logic [MC_W-1:0] w_phase;
  logic [KR_W-1:0] w_round;
  logic            w_last;
  logic            w_byte_last;
  logic [KR_W-1:0] w_key_idx;

  assign w_byte_last = (r_byte_cnt == LAST_BYTE);

  // Counters idle at zero outside RUN so every block starts at round 0, phase 0.
  seed_phase_counter u_phase_counter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (r_state != RUN),
    .i_en      (r_state == RUN),
    .o_phase   (w_phase),
    .o_round   (w_round),
    .o_last    (w_last)
  );

`ifdef SEED_DECRYPT_EN
  assign w_key_idx = KR_W'(NUM_ROUNDS - 1) - w_round;
`else
  assign w_key_idx = w_round;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    if (i_din_valid && w_byte_last) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = UNLOAD;
      UNLOAD:  if (w_byte_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_abort) w_state_next = IDLE;
  end

  always_comb begin
    o_busy         = (r_state != IDLE);
    o_din_ready    = (r_state == LOAD);
    o_lr_sel       = (r_state == RUN) || (r_state == UNLOAD);
    o_dp_en        = (r_state == LOAD) ? i_din_valid : o_lr_sel;
    o_main_counter = (r_state == RUN) ? w_phase : '0;
    o_key_req      = (r_state == RUN) && (w_phase == '0);
    o_key_round    = o_key_req ? w_key_idx : r_key_round;
    o_dout_valid   = (r_state == UNLOAD);
    o_done         = r_done;
  end

  // Byte counter restarts on every state change, so LOAD and UNLOAD each begin at zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_cnt  <= '0;
      r_done      <= 1'b0;
      r_key_round <= '0;
    end else begin
      if (w_state_next != r_state) begin
        r_byte_cnt <= '0;
      end else if (((r_state == LOAD) && i_din_valid) || (r_state == UNLOAD)) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      r_done      <= (r_state == UNLOAD) && w_byte_last && !i_abort;
      r_key_round <= o_key_round;
    end
  end

endmodule

// File: tb/tb_seed_round_sequencer.sv
// Scoreboard bench for seed_round_sequencer; honours SEED_DECRYPT_EN for key order.
module tb_seed_round_sequencer;

  logic       clk;
  logic       resetN;
  logic       start;
  logic       abort;
  logic       busy;
  logic       dinValid;
  logic       dinReady;
  logic       lrSel;
  logic       dpEn;
  logic [4:0] mainCounter;
  logic       keyReq;
  logic [3:0] keyRound;
  logic       doutValid;
  logic       done;

  int total = 0;
  int bad   = 0;
  int expKeys[$];

  seed_round_sequencer dut (
    .i_clk          (clk),
    .i_reset_n      (resetN),
    .i_start        (start),
    .i_abort        (abort),
    .o_busy         (busy),
    .i_din_valid    (dinValid),
    .o_din_ready    (dinReady),
    .o_lr_sel       (lrSel),
    .o_dp_en        (dpEn),
    .o_main_counter (mainCounter),
    .o_key_req      (keyReq),
    .o_key_round    (keyRound),
    .o_dout_valid   (doutValid),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int keyIdx(input int r);
`ifdef SEED_DECRYPT_EN
    return 15 - r;
`else
    return r;
`endif
  endfunction

  // Runs one block from IDLE; cycle 1 is the first cycle after the start-accept edge.
  task automatic run_block(input bit gapMode, input bit holdStart,
                           output int loadCyc, output int runCyc, output int unloadCyc,
                           output int lastDout, output int doneAt, output int doneCnt);
    int runIdx;
    bit seenDone;
    logic [3:0] expKey;
    logic [4:0] expMc;
    loadCyc = 0; runCyc = 0; unloadCyc = 0; lastDout = -1; doneAt = -1; doneCnt = 0;
    runIdx = 0;
    seenDone = 1'b0;
    for (int r = 0; r < 16; r++) expKeys.push_back(keyIdx(r));
    start = 1'b1;
    dinValid = 1'b0;
    @(posedge clk); #1;
    if (!holdStart) start = 1'b0;
    for (int t = 1; t <= 700 && !seenDone; t++) begin
      dinValid = gapMode ? (t % 2 == 0) : 1'b1;
      #1;
      if (dinReady) begin
        loadCyc++;
        total++;
        if (dpEn !== dinValid) begin
          bad++;
          $display("[TB] FAIL dp_en_load t=%0d got=%b want=%b", t, dpEn, dinValid);
        end
      end
      if (keyReq) begin
        total++;
        if (expKeys.size() == 0) begin
          bad++;
          $display("[TB] FAIL key_req_extra t=%0d got key_round=%0d want no request", t, keyRound);
        end else begin
          expKey = 4'(expKeys.pop_front());
          if (keyRound !== expKey) begin
            bad++;
            $display("[TB] FAIL key_round t=%0d got=%0d want=%0d", t, keyRound, expKey);
          end
        end
      end
      if (lrSel && !doutValid) begin
        expMc = 5'(runIdx % 24);
        total++;
        if (mainCounter !== expMc) begin
          bad++;
          $display("[TB] FAIL main_counter t=%0d got=%0d want=%0d", t, mainCounter, expMc);
        end
        runIdx++;
        runCyc++;
      end
      if (doutValid) begin
        unloadCyc++;
        lastDout = t;
      end
      if (done) begin
        doneCnt++;
        doneAt = t;
        seenDone = 1'b1;
      end
      @(posedge clk); #1;
    end
    dinValid = 1'b0;
    if (!seenDone) begin
      total++;
      bad++;
      $display("[TB] FAIL block_timeout got no done within 700 cycles want done");
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; start = 1'b0; abort = 1'b0; dinValid = 1'b0;
    #3;
    total++;
    if ({busy, dinReady, lrSel, dpEn, mainCounter, keyReq, keyRound, doutValid, done} !== 17'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {busy, dinReady, lrSel, dpEn, mainCounter, keyReq, keyRound, doutValid, done});
    end
    start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold_busy got=%b want=0", busy);
    end
    start = 1'b0;
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_block();
    int lc, rc, uc, ld, da, dc;
    run_block(1'b0, 1'b0, lc, rc, uc, ld, da, dc);
    total++; if (lc !== 16)  begin bad++; $display("[TB] FAIL full_load_cycles got=%0d want=16", lc); end
    total++; if (rc !== 384) begin bad++; $display("[TB] FAIL full_run_cycles got=%0d want=384", rc); end
    total++; if (uc !== 16)  begin bad++; $display("[TB] FAIL full_unload_cycles got=%0d want=16", uc); end
    total++; if (ld !== 416) begin bad++; $display("[TB] FAIL full_last_dout got=%0d want=416", ld); end
    total++; if (da !== 417) begin bad++; $display("[TB] FAIL full_done_cycle got=%0d want=417", da); end
    total++; if (dc !== 1)   begin bad++; $display("[TB] FAIL full_done_count got=%0d want=1", dc); end
    total++;
    if (expKeys.size() != 0) begin
      bad++;
      $display("[TB] FAIL full_keys_left got=%0d want=0", expKeys.size());
      expKeys.delete();
    end
    #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL done_pulse_width got done,busy=%b want=00", {done, busy});
    end
  endtask

  task automatic test_gaps();
    int lc, rc, uc, ld, da, dc;
    run_block(1'b1, 1'b0, lc, rc, uc, ld, da, dc);
    total++; if (lc !== 32)  begin bad++; $display("[TB] FAIL gap_load_cycles got=%0d want=32", lc); end
    total++; if (rc !== 384) begin bad++; $display("[TB] FAIL gap_run_cycles got=%0d want=384", rc); end
    total++; if (ld !== 432) begin bad++; $display("[TB] FAIL gap_last_dout got=%0d want=432", ld); end
    total++; if (da !== 433) begin bad++; $display("[TB] FAIL gap_done_cycle got=%0d want=433", da); end
    total++;
    if (expKeys.size() != 0) begin
      bad++;
      $display("[TB] FAIL gap_keys_left got=%0d want=0", expKeys.size());
      expKeys.delete();
    end
  endtask

  task automatic test_abort();
    int runIdx, keyCnt, doutCnt, doneCnt, busyCnt;
    bit fired;
    logic [3:0] expHeld;
    runIdx = 0; keyCnt = 0; fired = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 400 && !fired; t++) begin
      dinValid = 1'b1;
      #1;
      if (keyReq) keyCnt++;
      if (lrSel && !doutValid) begin
        if (runIdx == 7 * 24 + 10) begin
          total++;
          if (mainCounter !== 5'd10) begin
            bad++;
            $display("[TB] FAIL abort_point_phase got=%0d want=10", mainCounter);
          end
          abort = 1'b1;
          fired = 1'b1;
        end
        runIdx++;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    dinValid = 1'b0;
    #1;
    expHeld = 4'(keyIdx(7));
    total++;
    if ({busy, lrSel, dpEn, mainCounter} !== 8'h0) begin
      bad++;
      $display("[TB] FAIL abort_idle got busy,lr,dp,mc=%h want=0", {busy, lrSel, dpEn, mainCounter});
    end
    total++; if (keyCnt !== 8) begin bad++; $display("[TB] FAIL abort_key_count got=%0d want=8", keyCnt); end
    total++;
    if (keyRound !== expHeld) begin
      bad++;
      $display("[TB] FAIL abort_key_hold got=%0d want=%0d", keyRound, expHeld);
    end
    doutCnt = 0; doneCnt = 0; busyCnt = 0;
    for (int t = 0; t < 450; t++) begin
      @(posedge clk); #2;
      if (doutValid) doutCnt++;
      if (done) doneCnt++;
      if (busy) busyCnt++;
    end
    total++;
    if ({doutCnt, doneCnt, busyCnt} !== 96'h0) begin
      bad++;
      $display("[TB] FAIL abort_quiet got dout=%0d done=%0d busy=%0d want 0 0 0", doutCnt, doneCnt, busyCnt);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_start_same got busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt, lc, rc, uc, ld, da, dc;
    dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 500 && dcnt < 5; t++) begin
      dinValid = 1'b1;
      #1;
      if (doutValid) dcnt++;
      if (dcnt < 5) begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (dcnt !== 5) begin
      bad++;
      $display("[TB] FAIL reset_mid_reach got dout bytes=%0d want=5", dcnt);
    end
    resetN = 1'b0;
    #1;
    total++;
    if ({busy, dinReady, lrSel, dpEn, mainCounter, keyReq, keyRound, doutValid, done} !== 17'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_outputs got=%h want=0",
               {busy, dinReady, lrSel, dpEn, mainCounter, keyReq, keyRound, doutValid, done});
    end
    #2;
    resetN = 1'b1;
    dinValid = 1'b0;
    @(posedge clk); #1;
    run_block(1'b0, 1'b0, lc, rc, uc, ld, da, dc);
    total++; if (ld !== 416) begin bad++; $display("[TB] FAIL reset_mid_last_dout got=%0d want=416", ld); end
    total++; if (da !== 417) begin bad++; $display("[TB] FAIL reset_mid_done got=%0d want=417", da); end
    total++;
    if (expKeys.size() != 0) begin
      bad++;
      $display("[TB] FAIL reset_mid_keys_left got=%0d want=0", expKeys.size());
      expKeys.delete();
    end
  endtask

  task automatic test_back_to_back();
    int lc, rc, uc, ld, da, dc;
    run_block(1'b0, 1'b1, lc, rc, uc, ld, da, dc);
    total++; if (lc !== 16)  begin bad++; $display("[TB] FAIL b2b_load_cycles got=%0d want=16", lc); end
    total++; if (dc !== 1)   begin bad++; $display("[TB] FAIL b2b_done_count got=%0d want=1", dc); end
    total++; if (da !== 417) begin bad++; $display("[TB] FAIL b2b_done_cycle got=%0d want=417", da); end
    #1;
    total++;
    if ({dinReady, busy} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL b2b_restart got ready,busy=%b want=11", {dinReady, busy});
    end
    expKeys.delete();
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
